multi_ring_thermal_tuner: RTL
=============================

Name: multi_ring_thermal_tuner

Overview:
Multi-channel successor to the single-ring PDM thermal tuner. It drives NUM_CH ring heaters with first-order sigma-delta PDM streams, each from its own heater code. An auto-calibration sequencer sweeps each ring's heater code, samples a monitor photocurrent through a handshake, and locks each ring at the code of maximum monitored power. A host write port allows manual per-channel code override when the block is idle.

Parameters:
NUM_CH, 4, number of ring/heater channels (1..16)
CODE_W, 8, heater code width; PDM duty = code/2^CODE_W
CH_W, 2, channel index width, must be >= clog2(NUM_CH)
PDM_DIV, 4, clk cycles per PDM bit; must be >= 1
SWEEP_STEP, 16, code increment per sweep point; must be >= 1
SETTLE_TICKS, 8, PDM ticks waited after each code change before sampling
MON_W, 10, monitor power sample width (unsigned)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cal_start  in  1  one-cycle request to calibrate all channels
busy  out  1  high while calibration is running
cal_done  out  1  one-cycle pulse when the last channel is committed
wr_en  in  1  manual code write strobe
wr_ch  in  CH_W  manual write channel
wr_code  in  CODE_W  manual write code
mon_ch  out  CH_W  channel currently being measured
mon_req  out  1  sample request to monitor receiver
mon_valid  in  1  sample-valid acknowledge
mon_power  in  MON_W  monitored power sample, qualified by mon_valid
heater_out  out  NUM_CH  PDM heater enable, one bit per channel
lock_code  out  NUM_CH*CODE_W  current code of every channel; ch i is at [i*CODE_W +: CODE_W]

Behaviour:
- Reset (synchronous, active-high):
  - All codes, PDM accumulators, the divider, best_code and best_pwr go to 0.
  - heater_out=0, busy=0, cal_done=0, mon_req=0, mon_ch=0, FSM=IDLE.
  - Reset asserted mid-calibration aborts immediately; cal_done is not pulsed.
- PDM:
  - Divider counts 0..PDM_DIV-1; tick is asserted when the count = PDM_DIV-1.
  - On tick, per channel: {carry, acc} <= acc + code (CODE_W+1 bit sum); heater_out[i] <= carry. heater_out is registered and holds between ticks.
  - code=0 gives a constant 0. code=2^CODE_W-1 gives 1 on all but 1 of every 2^CODE_W ticks.
  - A code change takes effect on the next tick; the accumulator is not cleared.
- FSM states: IDLE, SET, SETTLE, REQ, WAIT, NEXT, COMMIT, DONE.
  - IDLE: cal_start -> SET with ch=0, code[0]=0, best_pwr=0, best_code=0. busy goes high in the cycle after cal_start.
  - SET: load code[ch] with the sweep code and clear the settle counter -> SETTLE.
  - SETTLE: count ticks; after SETTLE_TICKS ticks -> REQ.
  - REQ: drive mon_req=1 and mon_ch=ch -> WAIT.
  - WAIT: mon_req stays high until mon_valid. On the mon_valid cycle, if mon_power > best_pwr (strict), capture best_pwr and best_code. mon_req drops the following cycle -> NEXT. There is no timeout. mon_valid outside WAIT is ignored.
  - NEXT: if sweep code + SWEEP_STEP > 2^CODE_W-1 (evaluated in CODE_W+1 bits, no wrap) -> COMMIT; else advance the sweep code -> SET.
  - COMMIT: code[ch] <= best_code. If ch = NUM_CH-1 -> DONE; else ch++, reset the sweep code, best_pwr and best_code to 0 -> SET.
  - DONE: pulse cal_done for 1 cycle, drop busy -> IDLE.
- Ties: the earliest (lowest) code wins. If all samples are 0, the committed code is 0.
- cal_start while busy is ignored.
- During calibration, channels other than the one being measured keep their current codes.
- Manual write:
  - wr_en while IDLE and not busy, with wr_ch < NUM_CH: code[wr_ch] <= wr_code on the next edge.
  - wr_en while busy, or with wr_ch >= NUM_CH, is ignored.
  - wr_en and cal_start in the same cycle: the write is applied first, then calibration starts and overwrites that code.

Test Plan:
1. PDM duty: PDM_DIV=4, manual write ch1 code=64 -> heater_out[1] high exactly 256 of every 1024 ticks (4096 clk); other channels stay 0.
2. Code extremes: code 0 -> heater_out never 1; code 255 -> exactly one 0 per 256 ticks; rst mid-stream -> heater_out=0 on the next cycle.
3. Sweep lock: monitor returns power = 1000 - |code-96| for ch0 -> lock_code ch0 = 96; 16 sweep points; mon_req asserted 16 times per channel; cal_done pulses once after ch3.
4. Ties and flat response: constant mon_power=500 -> every channel locks to 0; all-zero power -> locks to 0.
5. Handshake stall: hold mon_valid low for 50 cycles -> mon_req stays high, FSM waits, no code advance; a mon_valid pulse while IDLE has no effect.
6. Interference: cal_start and wr_en during busy -> both ignored; rst asserted in SETTLE of ch2 -> busy=0, all codes 0, no cal_done.

Source files
------------

// File: rtl/multi_ring_thermal_tuner.sv
// Multi-ring PDM heater driver with sweep-and-lock auto-calibration.
// Ports: clk, rst (sync, active-high); cal_start/busy/cal_done sequencer control;
//   wr_en/wr_ch/wr_code manual code write (idle only); mon_ch/mon_req/mon_valid/
//   mon_power monitor handshake; heater_out PDM bits; lock_code packed channel codes.
module multi_ring_thermal_tuner #(
    parameter int NUM_CH       = 4,
    parameter int CODE_W       = 8,
    parameter int CH_W         = 2,
    parameter int PDM_DIV      = 4,
    parameter int SWEEP_STEP   = 16,
    parameter int SETTLE_TICKS = 8,
    parameter int MON_W        = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cal_start,
    output logic                     busy,
    output logic                     cal_done,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic [CODE_W-1:0]        wr_code,
    output logic [CH_W-1:0]          mon_ch,
    output logic                     mon_req,
    input  logic                     mon_valid,
    input  logic [MON_W-1:0]         mon_power,
    output logic [NUM_CH-1:0]        heater_out,
    output logic [NUM_CH*CODE_W-1:0] lock_code
);

    localparam int DIV_W = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
    localparam int SET_W = $clog2(SETTLE_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE, SET, SETTLE, REQ, WAIT, NEXT, COMMIT, DONE
    } state_t;

    state_t                         state;
    logic [DIV_W-1:0]               div;
    logic                           tick;
    logic [NUM_CH-1:0][CODE_W-1:0]  code;
    logic [CH_W-1:0]                ch;
    logic [CODE_W-1:0]              sweep;
    logic [CODE_W-1:0]              best_code;
    logic [MON_W-1:0]               best_pwr;
    logic [SET_W-1:0]               settle;
    logic [CODE_W:0]                sweep_next;
    logic                           last_point;
    logic                           wr_ok;

    assign lock_code = code;
    assign tick      = (div == DIV_W'(PDM_DIV - 1));

    // One extra bit so the last sweep point is detected without wrapping.
    assign sweep_next = {1'b0, sweep} + (CODE_W+1)'(SWEEP_STEP);
    assign last_point = sweep_next > (CODE_W+1)'((1 << CODE_W) - 1);

    assign wr_ok = wr_en && (state == IDLE) && !busy && (int'(wr_ch) < NUM_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // First-order sigma-delta: the carry out of acc + code is the PDM bit.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_pdm
        logic [CODE_W-1:0] acc;
        logic [CODE_W:0]   sum;
        logic              bit_q;

        assign sum           = {1'b0, acc} + {1'b0, code[i]};
        assign heater_out[i] = bit_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                acc   <= '0;
                bit_q <= 1'b0;
            end else if (tick) begin
                acc   <= sum[CODE_W-1:0];
                bit_q <= sum[CODE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code      <= '0;
            ch        <= '0;
            sweep     <= '0;
            best_code <= '0;
            best_pwr  <= '0;
            settle    <= '0;
            busy      <= 1'b0;
            cal_done  <= 1'b0;
            mon_req   <= 1'b0;
            mon_ch    <= '0;
        end else begin
            cal_done <= 1'b0;
            // Write lands first so a same-cycle cal_start can overwrite it.
            if (wr_ok) begin
                code[wr_ch] <= wr_code;
            end
            unique case (state)
                IDLE: begin
                    if (cal_start) begin
                        state     <= SET;
                        ch        <= '0;
                        code[0]   <= '0;
                        sweep     <= '0;
                        best_pwr  <= '0;
                        best_code <= '0;
                        busy      <= 1'b1;
                    end
                end
                SET: begin
                    code[ch] <= sweep;
                    settle   <= '0;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    if (tick) begin
                        settle <= settle + 1'b1;
                        if (settle == SET_W'(SETTLE_TICKS - 1)) begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    mon_req <= 1'b1;
                    mon_ch  <= ch;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (mon_valid) begin
                        // Strict compare keeps the lowest code on ties.
                        if (mon_power > best_pwr) begin
                            best_pwr  <= mon_power;
                            best_code <= sweep;
                        end
                        mon_req <= 1'b0;
                        state   <= NEXT;
                    end
                end
                NEXT: begin
                    if (last_point) begin
                        state <= COMMIT;
                    end else begin
                        sweep <= sweep_next[CODE_W-1:0];
                        state <= SET;
                    end
                end
                COMMIT: begin
                    code[ch] <= best_code;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        state <= DONE;
                    end else begin
                        ch        <= ch + 1'b1;
                        sweep     <= '0;
                        best_pwr  <= '0;
                        best_code <= '0;
                        state     <= SET;
                    end
                end
                DONE: begin
                    cal_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
